key_debounce: RTL and testbench

- Upstream conditioning stage for the flowing-water-light sequencer.
- Takes the raw, bouncing, asynchronous push-button input and synchronises it to clk.
- Filters contact bounce with a counter-based state machine.
- Emits clean single-cycle press, release and long-press pulses plus a debounced level. key_press drives the sequencer's button/start input directly.

---
 rtl/fwl_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/key_debounce.sv | 134 +++++++++++++
 tb/tb_key_debounce.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwl_pkg.sv
// Shared constants for the flowing-water-light design: key debounce FSM
// encoding and default timing used by the debouncer and the sequencer ticks.
package fwl_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned DB_MS   = 20;
  localparam int unsigned LONG_MS = 1000;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_FILT = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_FILT   = 2'd3;

  // Registered output bundle of the debouncer.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_hit;
  } key_evt_t;

  function automatic int ms_to_cycles(input int unsigned ms);
    return int'((CLK_HZ / 1000) * ms);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pins; the reset value lets
// each pin start at its own idle level.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // NOTE: async active-low reset in the sensitivity list; flops load the
  // pin's idle level so no false edge is seen when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      // NOTE: non-blocking so r_s2 takes the old r_s1, giving two stages.
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, counter-based bounce filter, and
// registered press / release / long-press pulses plus a debounced level.
module key_debounce
  import fwl_pkg::*;
#(
  parameter int DB_CYCLES      = ms_to_cycles(DB_MS),
  parameter int LONG_CYCLES    = ms_to_cycles(LONG_MS),
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] HOLD_PRE  = LONG_W'(LONG_CYCLES - 2);

  if (DB_CYCLES < 2) begin : g_chk_db
    $error("key_debounce: DB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DB_CYCLES) begin : g_chk_long
    $error("key_debounce: LONG_CYCLES must exceed DB_CYCLES");
  end

  logic              w_s2;
  logic              w_k;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_nxt;
  logic [LONG_W-1:0] r_hold_cnt;
  logic [LONG_W-1:0] w_hold_nxt;
  key_evt_t          r_evt;
  key_evt_t          w_evt_nxt;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (KEY_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (key_in),
    .o_q   (w_s2)
  );

  // Active-high pressed indication; the FSM never looks at the raw pin.
  assign w_k = w_s2 ^ KEY_ACTIVE_LOW;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_evt_nxt   = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_k) begin
          w_state_nxt = ST_PRESS_FILT;
          w_db_nxt    = '0;
        end
      end

      ST_PRESS_FILT: begin
        if (!w_k) begin
          w_state_nxt = ST_IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt     = ST_HELD;
          w_hold_nxt      = '0;
          w_evt_nxt.press = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!w_k) begin
          w_state_nxt = ST_REL_FILT;
          w_db_nxt    = '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
          // Saturating count; the pulse marks the one step onto the last value.
          w_hold_nxt         = r_hold_cnt + 1'b1;
          w_evt_nxt.long_hit = (r_hold_cnt == HOLD_PRE);
        end
      end

      ST_REL_FILT: begin
        // hold_cnt is deliberately untouched here so a release bounce only
        // pauses the long-press timer.
        if (w_k) begin
          w_state_nxt = ST_HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_evt_nxt.rel = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_evt_nxt.level = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_FILT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_evt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_evt      <= w_evt_nxt;
    end
  end

  assign key_level   = r_evt.level;
  assign key_press   = r_evt.press;
  assign key_release = r_evt.rel;
  assign key_long    = r_evt.long_hit;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance share one
// logical button; both are compared each cycle against a run-length model.
module tb_key_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic key_al = 1'b1;
  logic key_ah = 1'b0;

  logic lvl_al, prs_al, rel_al, lng_al;
  logic lvl_ah, prs_ah, rel_ah, lng_ah;

  always #5 clk = ~clk;

  key_debounce #(
    .DB_CYCLES      (DB),
    .LONG_CYCLES    (LONG),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_al),
    .key_level   (lvl_al),
    .key_press   (prs_al),
    .key_release (rel_al),
    .key_long    (lng_al)
  );

  key_debounce #(
    .DB_CYCLES      (DB),
    .LONG_CYCLES    (LONG),
    .KEY_ACTIVE_LOW (1'b0)
  ) dut_ah (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_ah),
    .key_level   (lvl_ah),
    .key_press   (prs_ah),
    .key_release (rel_ah),
    .key_long    (lng_ah)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted level flips after DB+1 consecutive opposite
  // samples; long fires when the count of steady pressed samples hits LONG-1.
  bit m_k_d1, m_k_d2, m_lvl;
  int m_run, m_hold;
  bit e_press, e_rel, e_long;

  int step_idx, cnt_press, cnt_rel, cnt_long, cnt_lvl;
  int idx_press, idx_rel, idx_long, idx_press_ah;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k_d1 = 1'b0; m_k_d2 = 1'b0; m_lvl = 1'b0;
    m_run = 0; m_hold = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge(input bit pressed);
    bit k;
    k = m_k_d2;
    m_k_d2 = m_k_d1;
    m_k_d1 = pressed;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (k != m_lvl) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_lvl = k;
        m_run = 0;
        if (k) begin
          e_press = 1'b1;
          m_hold  = 0;
        end else begin
          e_rel = 1'b1;
        end
      end
    end else begin
      if (m_lvl && m_run == 0 && m_hold < LONG - 1) begin
        m_hold++;
        if (m_hold == LONG - 1) e_long = 1'b1;
      end
      m_run = 0;
    end
  endtask

  task automatic clear_obs();
    step_idx = 0; cnt_press = 0; cnt_rel = 0; cnt_long = 0; cnt_lvl = 0;
    idx_press = -1; idx_rel = -1; idx_long = -1; idx_press_ah = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_al"}, {28'd0, lvl_al, prs_al, rel_al, lng_al}, 32'd0);
    check({tag, "_ah"}, {28'd0, lvl_ah, prs_ah, rel_ah, lng_ah}, 32'd0);
  endtask

  task automatic step(input bit p);
    @(negedge clk);
    key_al = ~p;
    key_ah = p;
    @(posedge clk);
    model_edge(p);
    #1;
    check("level_al", lvl_al, m_lvl);
    check("press_al", prs_al, e_press);
    check("rel_al",   rel_al, e_rel);
    check("long_al",  lng_al, e_long);
    check("level_ah", lvl_ah, m_lvl);
    check("press_ah", prs_ah, e_press);
    check("rel_ah",   rel_ah, e_rel);
    check("long_ah",  lng_ah, e_long);
    if (prs_al) begin cnt_press++; idx_press = step_idx; end
    if (rel_al) begin cnt_rel++;   idx_rel   = step_idx; end
    if (lng_al) begin cnt_long++;  idx_long  = step_idx; end
    if (lvl_al) cnt_lvl++;
    if (prs_ah) idx_press_ah = step_idx;
    step_idx++;
  endtask

  task automatic run(input bit p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  // Assert reset away from any clock edge and release it just after a
  // rising edge so the following step sees every edge.
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_async");
    repeat (cycles) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_obs();
    #1;
    check_all_zero("reset_init");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run(1'b0, 8);

    // Clean press and release.
    clear_obs();
    run(1'b1, 30);
    run(1'b0, 12);
    check("s1_press_idx", idx_press, 6);
    check("s1_press_ah_idx", idx_press_ah, 6);
    check("s1_long_idx", idx_long, 25);
    check("s1_rel_idx", idx_rel, 36);
    check("s1_press_cnt", cnt_press, 1);
    check("s1_long_cnt", cnt_long, 1);
    check("s1_rel_cnt", cnt_rel, 1);
    check("s1_level_cycles", cnt_lvl, 30);

    // Bounce rejection.
    clear_obs();
    for (int r = 0; r < 10; r++) begin
      run(1'b1, 3);
      run(1'b0, 1);
    end
    run(1'b0, 10);
    check("bounce_press_cnt", cnt_press, 0);
    check("bounce_rel_cnt", cnt_rel, 0);
    check("bounce_level_cycles", cnt_lvl, 0);

    // Short press.
    clear_obs();
    run(1'b1, 12);
    run(1'b0, 12);
    check("short_press_cnt", cnt_press, 1);
    check("short_rel_cnt", cnt_rel, 1);
    check("short_long_cnt", cnt_long, 0);

    // Release bounce while held pauses the long timer.
    clear_obs();
    run(1'b1, 10);
    run(1'b0, 2);
    run(1'b1, 20);
    check("hbounce_rel_cnt", cnt_rel, 0);
    check("hbounce_long_idx", idx_long, 28);
    check("hbounce_level_cycles", cnt_lvl, 26);
    run(1'b0, 12);
    check("hbounce_long_cnt", cnt_long, 1);
    check("hbounce_rel_end", cnt_rel, 1);

    // Asynchronous reset while held.
    clear_obs();
    run(1'b1, 12);
    check("rst_pre_level", lvl_al, 1'b1);
    apply_reset(3);
    clear_obs();
    run(1'b1, 10);
    check("rst_repress_idx", idx_press, 6);
    check("rst_repress_ah_idx", idx_press_ah, 6);
    check("rst_no_release", cnt_rel, 0);
    run(1'b0, 12);

    // Randomised segments with occasional resets.
    for (int s = 0; s < 80; s++) begin
      bit p;
      int len;
      if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 3));
      p   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 7));
      run(p, len);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
